// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words over a req/valid handshake,
// presents each word to the decoder and waits for the redirect decision.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        resolve_valid,
  input  logic [1:0]  jump_mux_signal,
  input  logic        branch_taken,
  input  logic [31:0] jump_offset,
  input  logic [31:0] jump_reg,
  input  logic        stall,
  output logic [31:0] pc,
  output logic        halted,
  output logic [31:0] retired_count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        resolve_fire;
  logic        unused_bits;

  // Handshakes: imem_req stays high for the whole FETCH state and a word is
  // taken only on a cycle where imem_valid=1 while in FETCH. On the decoder
  // side instr_valid marks a held word; it is consumed on a cycle with
  // resolve_valid=1 and stall=0 while in ISSUE. Both are ignored elsewhere.
  assign imem_req     = (state == FETCH);
  assign imem_addr    = pc;
  assign dbg_state    = state;
  assign pc_plus4     = pc + 32'd4;
  assign resolve_fire = resolve_valid && !stall;
  assign unused_bits  = ^{jump_offset[31:30], jump_reg[1:0]};

  always_comb begin
    next_pc = pc_plus4;
    case (jump_mux_signal)
      2'd0: next_pc = pc_plus4;
      2'd1: next_pc = branch_taken ? (pc + {jump_offset[29:0], 2'b00}) : pc_plus4;
      2'd2: next_pc = {jump_reg[31:2], 2'b00};
      2'd3: next_pc = {pc[31:18], jump_offset[15:0], 2'b00};
      default: next_pc = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      instruction   <= 32'd0;
      instr_valid   <= 1'b0;
      halted        <= 1'b0;
      retired_count <= 32'd0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem_valid) begin
            instruction <= imem_rdata;
            // Opcode 0 is the halt encoding; the word is kept for inspection.
            if (imem_rdata[31:26] == 6'd0) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state       <= ISSUE;
              instr_valid <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (resolve_fire) begin
            pc            <= next_pc;
            retired_count <= retired_count + 32'd1;
            instr_valid   <= 1'b0;
            state         <= FETCH;
          end
        end
        HALT: begin
          instr_valid <= 1'b0;
          halted      <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed vector table,
// hand-written corner sequences and randomized traffic against a PC model.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        resolve_valid;
  logic [1:0]  jump_mux_signal;
  logic        branch_taken;
  logic [31:0] jump_offset;
  logic [31:0] jump_reg;
  logic        stall;
  logic [31:0] pc;
  logic        halted;
  logic [31:0] retired_count;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_pc;
  logic [31:0] model_retired;
  logic [31:0] model_instr;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  mode;
    logic        taken;
    logic [31:0] off;
    logic [31:0] jreg;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[12];

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .instruction(instruction), .instr_valid(instr_valid),
    .resolve_valid(resolve_valid), .jump_mux_signal(jump_mux_signal),
    .branch_taken(branch_taken), .jump_offset(jump_offset),
    .jump_reg(jump_reg), .stall(stall),
    .pc(pc), .halted(halted), .retired_count(retired_count),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference next-PC computed from the architectural rules with plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [1:0] mode,
                                           input logic taken, input logic [31:0] off,
                                           input logic [31:0] jreg);
    logic [31:0] r;
    case (mode)
      2'd0: r = cur + 32'd4;
      2'd1: r = taken ? cur + off * 32'd4 : cur + 32'd4;
      2'd2: r = jreg & ~32'd3;
      default: r = (cur & 32'hFFFC_0000) | ((off & 32'h0000_FFFF) << 2);
    endcase
    return r;
  endfunction

  // Driver: waits (bounded) for a request, optionally idles with stray
  // resolve_valid pulses, then returns a word.
  task automatic do_fetch(input logic [31:0] rdata, input int delay);
    int n;
    logic [31:0] held_pc;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, model_pc);
    held_pc = pc;
    for (int i = 0; i < delay; i++) begin
      resolve_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("req_held", {31'd0, imem_req}, 32'd1);
      chk("pc_stable_fetch", pc, held_pc);
    end
    resolve_valid = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = rdata;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    model_instr = rdata;
    chk("instruction", instruction, model_instr);
    chk("req_dropped", {31'd0, imem_req}, 32'd0);
    if (rdata[31:26] != 6'd0) chk("instr_valid_set", {31'd0, instr_valid}, 32'd1);
  endtask

  // Driver: resolves the held instruction after stall_cycles of stalled
  // resolve_valid, optionally with a stray imem_valid pulse beforehand.
  task automatic do_resolve(input logic [1:0] mode, input logic taken, input logic [31:0] off,
                            input logic [31:0] jreg, input logic [31:0] exp_pc,
                            input int stall_cycles, input logic stray_valid);
    if (stray_valid) begin
      imem_valid = 1'b1;
      imem_rdata = 32'hFC00_0000 | $urandom;
      @(negedge clk);
      imem_valid = 1'b0;
      chk("stray_valid_ignored", instruction, model_instr);
    end
    jump_mux_signal = mode;
    branch_taken = taken;
    jump_offset = off;
    jump_reg = jreg;
    resolve_valid = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < stall_cycles; i++) begin
      @(negedge clk);
      chk("stall_pc", pc, model_pc);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_instr_valid", {31'd0, instr_valid}, 32'd1);
    end
    stall = 1'b0;
    @(negedge clk);
    resolve_valid = 1'b0;
    model_pc = exp_pc;
    model_retired = model_retired + 32'd1;
    chk("next_pc", pc, model_pc);
    chk("retired_count", retired_count, model_retired);
    chk("instr_valid_clear", {31'd0, instr_valid}, 32'd0);
    chk("refetch_req", {31'd0, imem_req}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    imem_rdata = 32'd0;
    imem_valid = 1'b0;
    resolve_valid = 1'b0;
    jump_mux_signal = 2'd0;
    branch_taken = 1'b0;
    jump_offset = 32'd0;
    jump_reg = 32'd0;
    stall = 1'b0;
    model_pc = 32'd0;
    model_retired = 32'd0;
    model_instr = 32'd0;

    vecs[0]  = '{32'h0422_1800, 2'd0, 1'b0, 32'd0,         32'd0,         32'h0000_0004};
    vecs[1]  = '{32'h0800_0000, 2'd0, 1'b0, 32'd0,         32'd0,         32'h0000_0008};
    vecs[2]  = '{32'h0C12_3456, 2'd0, 1'b0, 32'd0,         32'd0,         32'h0000_000C};
    vecs[3]  = '{32'hFFFF_FFFF, 2'd0, 1'b0, 32'd0,         32'd0,         32'h0000_0010};
    vecs[4]  = '{32'h1000_0001, 2'd1, 1'b1, 32'hFFFF_FFFE, 32'd0,         32'h0000_0008};
    vecs[5]  = '{32'h1400_0002, 2'd0, 1'b0, 32'd0,         32'd0,         32'h0000_000C};
    vecs[6]  = '{32'h1800_0003, 2'd0, 1'b0, 32'd0,         32'd0,         32'h0000_0010};
    vecs[7]  = '{32'h1000_0004, 2'd1, 1'b0, 32'hFFFF_FFFE, 32'd0,         32'h0000_0014};
    vecs[8]  = '{32'h2000_0005, 2'd2, 1'b0, 32'd0,         32'h0000_0103, 32'h0000_0100};
    vecs[9]  = '{32'h2400_0006, 2'd3, 1'b0, 32'h0000_1234, 32'd0,         32'h0000_48D0};
    vecs[10] = '{32'h2000_0007, 2'd2, 1'b0, 32'd0,         32'h0004_0010, 32'h0004_0010};
    vecs[11] = '{32'h2400_0008, 2'd3, 1'b0, 32'h0000_1234, 32'd0,         32'h0004_48D0};

    // T1 reset values
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_instruction", instruction, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_retired", retired_count, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'd0);

    // T2-T4 directed vectors
    for (int i = 0; i < 12; i++) begin
      do_fetch(vecs[i].rdata, 0);
      do_resolve(vecs[i].mode, vecs[i].taken, vecs[i].off, vecs[i].jreg, vecs[i].exp_pc, 0, 1'b0);
    end

    // T3 stall: three stalled cycles with resolve_valid high, then resolution
    do_fetch(32'h3000_0009, 0);
    do_resolve(2'd0, 1'b0, 32'd0, 32'd0, model_pc + 32'd4, 3, 1'b0);

    // T6 wrap: jump to the top word, then sequential wraps to zero
    do_fetch(32'h2000_000A, 1);
    do_resolve(2'd2, 1'b0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 0, 1'b0);
    do_fetch(32'h0400_000B, 0);
    do_resolve(2'd0, 1'b0, 32'd0, 32'd0, 32'h0000_0000, 0, 1'b0);
    chk("wrap_addr", imem_addr, 32'h0000_0000);

    // Randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      logic [1:0]  m;
      logic        t;
      logic [31:0] o;
      logic [31:0] r;
      m = 2'($urandom_range(0, 3));
      t = 1'($urandom_range(0, 1));
      o = $urandom;
      r = $urandom;
      do_fetch({6'($urandom_range(1, 63)), 26'($urandom)}, $urandom_range(0, 2));
      do_resolve(m, t, o, r, ref_next(model_pc, m, t, o, r),
                 $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    // T6 reset pulse mid-FETCH with a late imem_valid in IDLE
    chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_req_drop", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 32'h0444_4444;
    @(negedge clk);
    imem_valid = 1'b0;
    model_pc = 32'd0;
    model_retired = 32'd0;
    model_instr = 32'd0;
    chk("late_valid_instr", instruction, 32'd0);
    chk("late_valid_iv", {31'd0, instr_valid}, 32'd0);
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, 32'd0);
    chk("restart_retired", retired_count, 32'd0);
    do_fetch(32'h0422_1800, 0);
    do_resolve(2'd0, 1'b0, 32'd0, 32'd0, 32'h0000_0004, 0, 1'b0);

    // T5 halt on opcode 0; outputs frozen despite stray pulses
    do_fetch(32'h03AB_CDEF, 0);
    chk("halted", {31'd0, halted}, 32'd1);
    chk("halt_instr_valid", {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      resolve_valid = 1'($urandom_range(0, 1));
      imem_valid = 1'($urandom_range(0, 1));
      stall = 1'($urandom_range(0, 1));
      imem_rdata = 32'hFC00_0000 | $urandom;
      @(negedge clk);
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_instruction", instruction, 32'h03AB_CDEF);
      chk("halt_pc", pc, model_pc);
      chk("halt_retired", retired_count, model_retired);
      chk("halt_sticky", {31'd0, halted}, 32'd1);
    end
    resolve_valid = 1'b0;
    imem_valid = 1'b0;
    stall = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
